spi_slave: RTL



---
 rtl/spi_slave.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/spi_slave.sv
// SPI mode-0 slave, MSB first, oversampled on clk; no logic runs on sck.
// Define SPI_SLAVE_UNDERRUN_EN to add the tx_underrun pulse and underrun_cnt outputs.
module spi_slave #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] IDLE_TX     = 8'hFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sck,
  input  logic                  ss,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  load,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  new_data,
  output logic                  busy
`ifdef SPI_SLAVE_UNDERRUN_EN
  ,
  output logic                  tx_underrun,
  output logic [7:0]            underrun_cnt
`endif
);

  localparam int                CNT_W    = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [SYNC_STAGES-1:0] sck_sync_q, ss_sync_q, mosi_sync_q;
  logic                   sck_prev_q, ss_prev_q;
  logic                   sck_s, ss_s, mosi_s;
  logic                   sck_rise, sck_fall, ss_rise, ss_fall;

  state_t                 state_q;
  logic [CNT_W-1:0]       bit_cnt_q;
  logic [DATA_WIDTH-2:0]  rx_shift_q;
  logic [DATA_WIDTH-1:0]  tx_shift_q;
  logic [DATA_WIDTH-1:0]  buf_q;
  logic                   buf_full_q;
  logic [DATA_WIDTH-1:0]  data_out_q;
  logic                   new_data_q;

  logic                   consume;
  logic [DATA_WIDTH-1:0]  tx_next_d;
  logic [DATA_WIDTH-1:0]  rx_byte_d;

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign ss_s   = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sck_rise =  sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s &  sck_prev_q;
  assign ss_rise  =  ss_s  & ~ss_prev_q;
  assign ss_fall  = ~ss_s  &  ss_prev_q;

  assign tx_next_d = buf_full_q ? buf_q : IDLE_TX;
  assign rx_byte_d = {rx_shift_q, mosi_s};

  // The buffer is drained at frame start and at each byte boundary fall.
  always_comb begin
    // NOTE: default first so no path through this block leaves consume unassigned (no latch).
    consume = 1'b0;
    if (state_q == IDLE) begin
      consume = ss_fall;
    end else begin
      consume = ~ss_rise & sck_fall & (bit_cnt_q == '0);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking everywhere so each flop sees the values from before this edge.
    if (rst) begin
      sck_sync_q  <= '0;
      ss_sync_q   <= '0;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      ss_prev_q   <= 1'b0;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      buf_q       <= '0;
      buf_full_q  <= 1'b0;
      data_out_q  <= '0;
      new_data_q  <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sck_prev_q  <= sck_s;
      ss_prev_q   <= ss_s;
      new_data_q  <= 1'b0;

      // A load coinciding with a consume is always captured, even when the buffer was full.
      if (consume) begin
        tx_shift_q <= tx_next_d;
        buf_full_q <= load;
        if (load) buf_q <= data_in;
      end else if (load && !buf_full_q) begin
        buf_q      <= data_in;
        buf_full_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (ss_fall) begin
            state_q   <= SHIFT;
            bit_cnt_q <= '0;
          end
        end
        SHIFT: begin
          if (ss_rise) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
          end else if (sck_rise) begin
            rx_shift_q <= rx_byte_d[DATA_WIDTH-2:0];
            if (bit_cnt_q == LAST_BIT) begin
              data_out_q <= rx_byte_d;
              new_data_q <= 1'b1;
              bit_cnt_q  <= '0;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end else if (sck_fall && bit_cnt_q != '0) begin
            tx_shift_q <= {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SPI_SLAVE_UNDERRUN_EN
  logic       underrun_evt;
  logic       tx_underrun_q;
  logic [7:0] underrun_cnt_q;

  assign underrun_evt = consume & ~buf_full_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_underrun_q  <= 1'b0;
      underrun_cnt_q <= '0;
    end else begin
      tx_underrun_q <= underrun_evt;
      if (underrun_evt && underrun_cnt_q != 8'hFF) underrun_cnt_q <= underrun_cnt_q + 8'd1;
    end
  end

  assign tx_underrun  = tx_underrun_q;
  assign underrun_cnt = underrun_cnt_q;
`endif

  // tx_shift is cleared outside a frame, so its MSB doubles as the idle-low miso.
  assign miso     = tx_shift_q[DATA_WIDTH-1];
  assign tx_ready = ~buf_full_q;
  assign data_out = data_out_q;
  assign new_data = new_data_q;
  assign busy     = (state_q == SHIFT);

endmodule
